// File: rtl/muldiv_pkg.sv
// muldiv_pkg
//   Shared types and constants for the dual-core multiply/divide arbiter.
//   muldiv_op_t    : operation code carried by each core's request
//   muldiv_state_t : arbiter FSM states
//   ITER_DEFAULT   : iterations per operation (equals operand width)
//   DIV0_LO        : quotient returned on divide by zero
package muldiv_pkg;

  localparam int          ITER_DEFAULT = 32;
  localparam logic [31:0] DIV0_LO      = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    MULT  = 2'b00,
    MULTU = 2'b01,
    DIV   = 2'b10,
    DIVU  = 2'b11
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } muldiv_state_t;

  function automatic logic op_is_div(input muldiv_op_t op);
    return (op == DIV) || (op == DIVU);
  endfunction

  function automatic logic op_is_signed(input muldiv_op_t op);
    return (op == MULT) || (op == DIV);
  endfunction

  // Magnitude of a possibly-signed operand. 0x8000_0000 maps to itself,
  // which is the correct unsigned magnitude.
  function automatic logic [31:0] abs32(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/seq_muldiv_core.sv
// seq_muldiv_core
//   Iterative multiply/divide datapath shared by both cores.
//   Multiply: radix-2 shift-add on operand magnitudes.
//   Divide:   restoring shift-subtract on operand magnitudes.
//   Signs are captured at start and applied combinationally on the result.
//   Optional feature macro: MULDIV_FAST_MULT_EN (single-cycle multiplier;
//   mult/multu complete at start and report direct_o).
// Ports
//   clk, reset   : clock, synchronous active-low reset
//   start_i      : load op/operands (arbiter accept)
//   step_i       : perform one iteration
//   op_i, a_i, b_i : operation and operands, sampled on start_i
//   direct_o     : result is complete at start (no iterations needed)
//   last_o       : current step is the final iteration
//   hi_o, lo_o   : sign-corrected result
module seq_muldiv_core
  import muldiv_pkg::*;
#(
  parameter int ITER = ITER_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic        step_i,
  input  muldiv_op_t  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        direct_o,
  output logic        last_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam int CW = $clog2(ITER);

  // acc: upper product half / partial remainder
  // shr: multiplier shifting out, quotient shifting in
  // mag: multiplicand or divisor magnitude
  logic [31:0]   acc_q, acc_d;
  logic [31:0]   shr_q, shr_d;
  logic [31:0]   mag_q, mag_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          is_div_q, is_div_d;
  logic          neg_hi_q, neg_hi_d;
  logic          neg_lo_q, neg_lo_d;

  logic        sgn, sa, sb, div0;
  logic [32:0] rem_sh;
  logic        rem_ge;
  logic [31:0] diff;
  logic [32:0] sum;
  logic [63:0] prod_mag;
  logic [63:0] prod_neg;

  assign sgn  = op_is_signed(op_i);
  assign sa   = sgn & a_i[31];
  assign sb   = sgn & b_i[31];
  assign div0 = op_is_div(op_i) && (b_i == 32'd0);

`ifdef MULDIV_FAST_MULT_EN
  logic [63:0] ext_a, ext_b, fast_prod;
  assign ext_a     = {{32{sa}}, a_i};
  assign ext_b     = {{32{sb}}, b_i};
  // Low 64 bits of the sign-extended product are exact for both signednesses.
  assign fast_prod = ext_a * ext_b;
  assign direct_o  = div0 | ~op_is_div(op_i);
`else
  assign direct_o  = div0;
`endif

  // Restoring divide: the true difference is below the divisor whenever
  // rem_sh >= mag, so the 32-bit wrap-around subtraction is exact.
  assign rem_sh = {acc_q, shr_q[31]};
  assign rem_ge = rem_sh >= {1'b0, mag_q};
  assign diff   = rem_sh[31:0] - mag_q;

  assign sum = {1'b0, acc_q} + (shr_q[0] ? {1'b0, mag_q} : 33'd0);

  assign last_o = (cnt_q == CW'(ITER - 1));

  always_comb begin
    acc_d    = acc_q;
    shr_d    = shr_q;
    mag_d    = mag_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    neg_hi_d = neg_hi_q;
    neg_lo_d = neg_lo_q;
    if (start_i) begin
      cnt_d    = '0;
      is_div_d = op_is_div(op_i);
      neg_hi_d = 1'b0;
      neg_lo_d = 1'b0;
      mag_d    = 32'd0;
      if (div0) begin
        acc_d = a_i;
        shr_d = DIV0_LO;
`ifdef MULDIV_FAST_MULT_EN
      end else if (!op_is_div(op_i)) begin
        {acc_d, shr_d} = fast_prod;
`endif
      end else if (op_is_div(op_i)) begin
        acc_d    = 32'd0;
        shr_d    = abs32(a_i, sgn);
        mag_d    = abs32(b_i, sgn);
        neg_lo_d = sa ^ sb;
        neg_hi_d = sa;
      end else begin
        acc_d    = 32'd0;
        shr_d    = abs32(b_i, sgn);
        mag_d    = abs32(a_i, sgn);
        neg_lo_d = sa ^ sb;
        neg_hi_d = sa ^ sb;
      end
    end else if (step_i) begin
      cnt_d = cnt_q + CW'(1);
      if (is_div_q) begin
        if (rem_ge) begin
          acc_d = diff;
          shr_d = {shr_q[30:0], 1'b1};
        end else begin
          acc_d = rem_sh[31:0];
          shr_d = {shr_q[30:0], 1'b0};
        end
      end else begin
        acc_d = sum[32:1];
        shr_d = {sum[0], shr_q[31:1]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      acc_q    <= '0;
      shr_q    <= '0;
      mag_q    <= '0;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_hi_q <= 1'b0;
      neg_lo_q <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      shr_q    <= shr_d;
      mag_q    <= mag_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      neg_hi_q <= neg_hi_d;
      neg_lo_q <= neg_lo_d;
    end
  end

  // Product sign applies to the full 64-bit value; quotient and remainder
  // carry independent signs.
  assign prod_mag = {acc_q, shr_q};
  assign prod_neg = ~prod_mag + 64'd1;

  always_comb begin
    if (is_div_q) begin
      hi_o = neg_hi_q ? (~acc_q + 32'd1) : acc_q;
      lo_o = neg_lo_q ? (~shr_q + 32'd1) : shr_q;
    end else begin
      hi_o = neg_lo_q ? prod_neg[63:32] : prod_mag[63:32];
      lo_o = neg_lo_q ? prod_neg[31:0]  : prod_mag[31:0];
    end
  end

endmodule

// File: rtl/muldiv_arbiter.sv
// muldiv_arbiter
//   Round-robin arbiter sharing one iterative multiply/divide engine
//   between two cores. Grants, sequences the engine and returns HI/LO
//   with a one-cycle done pulse to the owning core.
//   Optional feature macro: MULDIV_FAST_MULT_EN (mult/multu complete in
//   one cycle, IDLE -> DONE).
// Ports
//   clk, reset        : clock, synchronous active-low reset
//   req0/1            : core request, held until that core's done
//   op0/1, a0/1, b0/1 : operation and operands per core
//   gnt0/1            : registered accept pulse
//   done0/1           : registered result-valid pulse
//   stall0/1          : reqN & ~doneN, to the core's execute stall
//   hi_out, lo_out    : result, held until the next done
//   owner, busy       : current engine owner, engine in BUSY/DONE
//
// state | meaning
// IDLE  | engine free, arbitrate pending requests
// BUSY  | iterating, one step per cycle
// DONE  | result stable in the core, capture and pulse done
module muldiv_arbiter
  import muldiv_pkg::*;
#(
  parameter int ITER = ITER_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic [1:0]  op0,
  input  logic [1:0]  op1,
  input  logic [31:0] a0,
  input  logic [31:0] b0,
  input  logic [31:0] a1,
  input  logic [31:0] b1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic        stall0,
  output logic        stall1,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic        owner,
  output logic        busy
);

  muldiv_state_t state_q, state_d;
  logic          prio_q, prio_d;
  logic          owner_q, owner_d;
  logic          gnt0_q, gnt0_d;
  logic          gnt1_q, gnt1_d;
  logic          done0_q, done0_d;
  logic          done1_q, done1_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;

  logic          sel;
  logic          accept;
  muldiv_op_t    op_sel;
  logic [31:0]   a_sel, b_sel;
  logic          core_direct, core_last;
  logic [31:0]   core_hi, core_lo;

  // A lone requester wins outright; on contention the pointer decides.
  assign sel    = (req0 & req1) ? prio_q : req1;
  assign accept = (state_q == IDLE) & (req0 | req1);
  assign op_sel = sel ? muldiv_op_t'(op1) : muldiv_op_t'(op0);
  assign a_sel  = sel ? a1 : a0;
  assign b_sel  = sel ? b1 : b0;

  seq_muldiv_core #(
    .ITER (ITER)
  ) u_core (
    .clk      (clk),
    .reset    (reset),
    .start_i  (accept),
    .step_i   (state_q == BUSY),
    .op_i     (op_sel),
    .a_i      (a_sel),
    .b_i      (b_sel),
    .direct_o (core_direct),
    .last_o   (core_last),
    .hi_o     (core_hi),
    .lo_o     (core_lo)
  );

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    owner_d = owner_q;
    gnt0_d  = 1'b0;
    gnt1_d  = 1'b0;
    done0_d = 1'b0;
    done1_d = 1'b0;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          owner_d = sel;
          prio_d  = ~sel;
          gnt0_d  = ~sel;
          gnt1_d  = sel;
          state_d = core_direct ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (core_last) state_d = DONE;
      end
      DONE: begin
        hi_d    = core_hi;
        lo_d    = core_lo;
        done0_d = ~owner_q;
        done1_d = owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      owner_q <= 1'b0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      owner_q <= owner_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign gnt0   = gnt0_q;
  assign gnt1   = gnt1_q;
  assign done0  = done0_q;
  assign done1  = done1_q;
  assign stall0 = req0 & ~done0_q;
  assign stall1 = req1 & ~done1_q;
  assign hi_out = hi_q;
  assign lo_out = lo_q;
  assign owner  = owner_q;
  assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_muldiv_arbiter.sv
module tb_muldiv_arbiter;

  localparam int CLK_P = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1;
  logic [1:0]  op0, op1;
  logic [31:0] a0, b0, a1, b1;
  logic        gnt0, gnt1, done0, done1, stall0, stall1;
  logic [31:0] hi_out, lo_out;
  logic        owner, busy;

  int   checks = 0;
  int   errors = 0;
  logic prio_m;

  typedef struct {
    bit          timeout;
    time         t_gnt;
    time         t_done;
    int          lat;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        owner_g;
    logic        busy_g;
    logic        stall_g;
    logic        stall_d;
  } obs_t;

  muldiv_arbiter dut (
    .clk    (clk),
    .reset  (reset),
    .req0   (req0),
    .req1   (req1),
    .op0    (op0),
    .op1    (op1),
    .a0     (a0),
    .b0     (b0),
    .a1     (a1),
    .b1     (b1),
    .gnt0   (gnt0),
    .gnt1   (gnt1),
    .done0  (done0),
    .done1  (done1),
    .stall0 (stall0),
    .stall1 (stall1),
    .hi_out (hi_out),
    .lo_out (lo_out),
    .owner  (owner),
    .busy   (busy)
  );

  always #(CLK_P / 2) clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  // Reference results from plain integer arithmetic: {hi, lo}.
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, q, r;
    logic [31:0] uq, ur;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = 64'd0;
    case (op)
      2'b00: p = sa * sb;
      2'b01: p = {32'd0, a} * {32'd0, b};
      2'b10: begin
        if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
        else begin
          uq = a / b;
          ur = a % b;
          p  = {ur, uq};
        end
      end
    endcase
    return p;
  endfunction

  // Cycles from the grant cycle to the done cycle.
  function automatic int exp_lat(input logic [1:0] op, input logic [31:0] b);
    if (op[1] && b == 32'd0) return 1;
`ifdef MULDIV_FAST_MULT_EN
    if (!op[1]) return 1;
`endif
    return 33;
  endfunction

  task automatic set_req(input int core, input logic v, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    if (core == 0) begin req0 = v; op0 = op; a0 = a; b0 = b; end
    else           begin req1 = v; op1 = op; a1 = a; b1 = b; end
  endtask

  // Drives one request like a core would and records what it observes.
  task automatic issue(input int core, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, output obs_t o);
    bit seen;
    o = '{timeout: 1'b0, t_gnt: 0, t_done: 0, lat: 0, hi: '0, lo: '0,
          owner_g: 1'b0, busy_g: 1'b0, stall_g: 1'b0, stall_d: 1'b0};
    @(posedge clk); #1;
    set_req(core, 1'b1, op, a, b);
    seen = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if ((core == 0) ? gnt0 : gnt1) seen = 1;
    end
    if (!seen) begin
      o.timeout = 1;
      set_req(core, 1'b0, op, a, b);
      return;
    end
    o.t_gnt   = $time;
    o.owner_g = owner;
    o.busy_g  = busy;
    o.stall_g = (core == 0) ? stall0 : stall1;
    prio_m    = (core == 0);
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      o.lat++;
      if ((core == 0) ? done0 : done1) seen = 1;
    end
    if (!seen) o.timeout = 1;
    o.t_done  = $time;
    o.hi      = hi_out;
    o.lo      = lo_out;
    o.stall_d = (core == 0) ? stall0 : stall1;
    set_req(core, 1'b0, op, a, b);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    set_req(0, 1'b0, 2'b00, 32'd0, 32'd0);
    set_req(1, 1'b0, 2'b00, 32'd0, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (gnt0 !== 1'b0)    begin errors++; $display("FAIL reset_gnt0 got %b exp 0", gnt0); end
    checks++; if (gnt1 !== 1'b0)    begin errors++; $display("FAIL reset_gnt1 got %b exp 0", gnt1); end
    checks++; if (done0 !== 1'b0)   begin errors++; $display("FAIL reset_done0 got %b exp 0", done0); end
    checks++; if (done1 !== 1'b0)   begin errors++; $display("FAIL reset_done1 got %b exp 0", done1); end
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (owner !== 1'b0)   begin errors++; $display("FAIL reset_owner got %b exp 0", owner); end
    checks++; if (hi_out !== 32'd0) begin errors++; $display("FAIL reset_hi got %h exp 0", hi_out); end
    checks++; if (lo_out !== 32'd0) begin errors++; $display("FAIL reset_lo got %h exp 0", lo_out); end
    @(posedge clk); #1;
    reset  = 1'b1;
    prio_m = 1'b0;
  endtask

  task automatic test_multu();
    obs_t        o;
    logic [63:0] e;
    e = model(2'b01, 32'hFFFF_FFFF, 32'd2);
    issue(0, 2'b01, 32'hFFFF_FFFF, 32'd2, o);
    checks++; if (o.timeout !== 1'b0)         begin errors++; $display("FAIL multu_timeout got %b exp 0", o.timeout); end
    checks++; if (o.lat != exp_lat(2'b01, 32'd2)) begin errors++; $display("FAIL multu_latency got %0d exp %0d", o.lat, exp_lat(2'b01, 32'd2)); end
    checks++; if (o.hi !== e[63:32])          begin errors++; $display("FAIL multu_hi got %h exp %h", o.hi, e[63:32]); end
    checks++; if (o.lo !== e[31:0])           begin errors++; $display("FAIL multu_lo got %h exp %h", o.lo, e[31:0]); end
    checks++; if (o.owner_g !== 1'b0)         begin errors++; $display("FAIL multu_owner got %b exp 0", o.owner_g); end
    checks++; if (o.busy_g !== 1'b1)          begin errors++; $display("FAIL multu_busy got %b exp 1", o.busy_g); end
    checks++; if (o.stall_g !== 1'b1)         begin errors++; $display("FAIL multu_stall_gnt got %b exp 1", o.stall_g); end
    checks++; if (o.stall_d !== 1'b0)         begin errors++; $display("FAIL multu_stall_done got %b exp 0", o.stall_d); end
  endtask

  task automatic test_signed_div();
    obs_t        o;
    logic [63:0] e;
    e = model(2'b10, -32'sd7, 32'd2);
    issue(1, 2'b10, -32'sd7, 32'd2, o);
    checks++; if (o.timeout !== 1'b0)  begin errors++; $display("FAIL sdiv_timeout got %b exp 0", o.timeout); end
    checks++; if (o.lat != 33)         begin errors++; $display("FAIL sdiv_latency got %0d exp 33", o.lat); end
    checks++; if (o.hi !== e[63:32])   begin errors++; $display("FAIL sdiv_hi got %h exp %h", o.hi, e[63:32]); end
    checks++; if (o.lo !== e[31:0])    begin errors++; $display("FAIL sdiv_lo got %h exp %h", o.lo, e[31:0]); end
    checks++; if (o.owner_g !== 1'b1)  begin errors++; $display("FAIL sdiv_owner got %b exp 1", o.owner_g); end
    e = model(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(0, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, o);
    checks++; if (o.hi !== e[63:32])   begin errors++; $display("FAIL ovf_hi got %h exp %h", o.hi, e[63:32]); end
    checks++; if (o.lo !== e[31:0])    begin errors++; $display("FAIL ovf_lo got %h exp %h", o.lo, e[31:0]); end
  endtask

  task automatic test_simultaneous();
    for (int pass = 0; pass < 2; pass++) begin
      obs_t        o0, o1, of, os;
      logic        exp_first;
      logic [1:0]  p0, p1;
      logic [31:0] x0, y0, x1, y1;
      logic [63:0] e0, e1;
      int          bad;
      bit          first_is0;
      exp_first = prio_m;
      p0 = 2'($urandom_range(0, 3)); x0 = $urandom; y0 = $urandom | 32'd1;
      p1 = 2'($urandom_range(0, 3)); x1 = $urandom; y1 = $urandom | 32'd1;
      e0 = model(p0, x0, y0);
      e1 = model(p1, x1, y1);
      bad = 0;
      fork
        issue(0, p0, x0, y0, o0);
        issue(1, p1, x1, y1, o1);
        begin
          bit got;
          got = 0;
          @(posedge clk); #1;
          for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (((exp_first == 1'b0) ? stall1 : stall0) !== 1'b1) bad++;
            if ((exp_first == 1'b0) ? gnt1 : gnt0) got = 1;
          end
          if (!got) bad++;
        end
      join
      first_is0 = (o0.t_gnt < o1.t_gnt);
      of = first_is0 ? o0 : o1;
      os = first_is0 ? o1 : o0;
      checks++; if ((o0.timeout | o1.timeout) !== 1'b0) begin errors++; $display("FAIL sim%0d_timeout exp none", pass); end
      checks++; if (first_is0 !== (exp_first == 1'b0))  begin errors++; $display("FAIL sim%0d_order core0_first got %b exp %b", pass, first_is0, exp_first == 1'b0); end
      checks++; if (os.t_gnt - of.t_done != CLK_P)      begin errors++; $display("FAIL sim%0d_second_gnt gap got %0t exp %0d", pass, os.t_gnt - of.t_done, CLK_P); end
      checks++; if (bad != 0)                           begin errors++; $display("FAIL sim%0d_loser_stall bad_cycles got %0d exp 0", pass, bad); end
      checks++; if ({o0.hi, o0.lo} !== e0)              begin errors++; $display("FAIL sim%0d_core0_result got %h exp %h", pass, {o0.hi, o0.lo}, e0); end
      checks++; if ({o1.hi, o1.lo} !== e1)              begin errors++; $display("FAIL sim%0d_core1_result got %h exp %h", pass, {o1.hi, o1.lo}, e1); end
    end
  endtask

  task automatic test_div0();
    obs_t o;
    issue(0, 2'b11, 32'h0000_1234, 32'd0, o);
    checks++; if (o.lat != 1)               begin errors++; $display("FAIL divu0_latency got %0d exp 1", o.lat); end
    checks++; if (o.hi !== 32'h0000_1234)   begin errors++; $display("FAIL divu0_hi got %h exp 00001234", o.hi); end
    checks++; if (o.lo !== 32'hFFFF_FFFF)   begin errors++; $display("FAIL divu0_lo got %h exp ffffffff", o.lo); end
    issue(1, 2'b10, 32'hFFFF_FF00, 32'd0, o);
    checks++; if (o.lat != 1)               begin errors++; $display("FAIL div0_latency got %0d exp 1", o.lat); end
    checks++; if (o.hi !== 32'hFFFF_FF00)   begin errors++; $display("FAIL div0_hi got %h exp ffffff00", o.hi); end
    checks++; if (o.lo !== 32'hFFFF_FFFF)   begin errors++; $display("FAIL div0_lo got %h exp ffffffff", o.lo); end
  endtask

  task automatic test_fast_mult();
    obs_t        o;
    logic [63:0] e;
    e = model(2'b00, -32'sd3, 32'd5);
    issue(0, 2'b00, -32'sd3, 32'd5, o);
    checks++; if (o.lat != exp_lat(2'b00, 32'd5)) begin errors++; $display("FAIL mult_latency got %0d exp %0d", o.lat, exp_lat(2'b00, 32'd5)); end
    checks++; if ({o.hi, o.lo} !== e)             begin errors++; $display("FAIL mult_result got %h exp %h", {o.hi, o.lo}, e); end
  endtask

  task automatic test_reset_mid();
    obs_t        o;
    bit          seen;
    int          spurious;
    logic [31:0] x, y;
    logic [63:0] e;
    x = $urandom; y = $urandom | 32'd1;
    @(posedge clk); #1;
    set_req(0, 1'b1, 2'b11, x, y);
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (gnt0) seen = 1;
    end
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL rstmid_gnt got %b exp 1", seen); end
    repeat (10) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_inflight got %b exp 1", busy); end
    reset = 1'b0;
    req0  = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL rstmid_busy got %b exp 0", busy); end
    checks++; if (hi_out !== 32'd0) begin errors++; $display("FAIL rstmid_hi got %h exp 0", hi_out); end
    checks++; if (lo_out !== 32'd0) begin errors++; $display("FAIL rstmid_lo got %h exp 0", lo_out); end
    reset  = 1'b1;
    prio_m = 1'b0;
    spurious = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done0 || done1 || busy) spurious++;
    end
    checks++; if (spurious != 0) begin errors++; $display("FAIL rstmid_no_done got %0d exp 0", spurious); end
    x = $urandom; y = $urandom | 32'd1;
    e = model(2'b10, x, y);
    issue(1, 2'b10, x, y, o);
    checks++; if (o.lat != 33)            begin errors++; $display("FAIL rstmid_after_latency got %0d exp 33", o.lat); end
    checks++; if ({o.hi, o.lo} !== e)     begin errors++; $display("FAIL rstmid_after_result got %h exp %h", {o.hi, o.lo}, e); end
  endtask

  task automatic test_back_to_back();
    obs_t        o0, o1;
    logic [1:0]  p1;
    logic [31:0] x0, y0, x1, y1;
    logic [63:0] e0, e1;
    x0 = $urandom; y0 = $urandom | 32'd1;
    p1 = 2'($urandom_range(0, 3)); x1 = $urandom; y1 = $urandom;
    e0 = model(2'b10, x0, y0);
    e1 = model(p1, x1, y1);
    fork
      issue(0, 2'b10, x0, y0, o0);
      begin
        repeat (5) @(negedge clk);
        issue(1, p1, x1, y1, o1);
      end
    join
    checks++; if (o1.t_gnt - o0.t_done != CLK_P) begin errors++; $display("FAIL b2b_wait_gnt gap got %0t exp %0d", o1.t_gnt - o0.t_done, CLK_P); end
    checks++; if ({o0.hi, o0.lo} !== e0)         begin errors++; $display("FAIL b2b_first got %h exp %h", {o0.hi, o0.lo}, e0); end
    checks++; if ({o1.hi, o1.lo} !== e1)         begin errors++; $display("FAIL b2b_second got %h exp %h", {o1.hi, o1.lo}, e1); end
    checks++; if (o1.lat != exp_lat(p1, y1))     begin errors++; $display("FAIL b2b_latency got %0d exp %0d", o1.lat, exp_lat(p1, y1)); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 24; n++) begin
      obs_t        o;
      int          core;
      int          k;
      logic [1:0]  p;
      logic [31:0] x, y;
      logic [63:0] e;
      core = int'($urandom_range(0, 1));
      p    = 2'($urandom_range(0, 3));
      k    = int'($urandom_range(0, 9));
      x    = $urandom;
      y    = $urandom;
      case (k)
        0: y = 32'd0;
        1: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
        2: begin x = 32'hFFFF_FFFF; y = 32'($urandom_range(1, 9)); end
        3: y = 32'($urandom_range(1, 300));
        default: ;
      endcase
      e = model(p, x, y);
      issue(core, p, x, y, o);
      checks++; if (o.timeout !== 1'b0)         begin errors++; $display("FAIL rnd%0d_timeout op %0d", n, p); end
      checks++; if (o.lat != exp_lat(p, y))     begin errors++; $display("FAIL rnd%0d_latency op %0d got %0d exp %0d", n, p, o.lat, exp_lat(p, y)); end
      checks++; if ({o.hi, o.lo} !== e)         begin errors++; $display("FAIL rnd%0d_result op %0d a %h b %h got %h exp %h", n, p, x, y, {o.hi, o.lo}, e); end
      checks++; if (o.owner_g !== 1'(core))     begin errors++; $display("FAIL rnd%0d_owner got %b exp %0d", n, o.owner_g, core); end
    end
  endtask

  initial begin
    reset = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    op0 = 2'b00; op1 = 2'b00;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    prio_m = 1'b0;
    test_reset();
    test_simultaneous();
    test_multu();
    test_signed_div();
    test_div0();
    test_fast_mult();
    test_reset_mid();
    test_back_to_back();
    test_random();
    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_arbiter.md
# muldiv_arbiter

Shares one iterative multiply/divide engine between the two cores of the dual-core processor. Each core's Execute stage raises a request with its operation and operands. The arbiter grants the engine round-robin and sequences the 32-step shift/add or shift/subtract iterations. It returns the 64-bit HI/LO result with a one-cycle done pulse to the owning core, which writes its own HI/LO registers.

## Interface
- ITER, 32, iteration count per multiply/divide operation; equals operand width.
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- req0 / req1  in  1  core 0 / core 1 request; held high with stable op/operands until that core's done pulse.
- op0 / op1  in  2  operation: 00 mult, 01 multu, 10 div, 11 divu.
- a0, b0 / a1, b1  in  32  operands; A is the multiplicand or dividend, B is the multiplier or divisor.
- gnt0 / gnt1  out  1  registered one-cycle pulse: the request was accepted.
- done0 / done1  out  1  registered one-cycle pulse: the result is valid on hi_out/lo_out.
- stall0 / stall1  out  1  combinational: reqN & ~doneN; drives that core's stall_execute_now.
- hi_out, lo_out  out  32  result: product[63:32]/[31:0], or remainder/quotient; held until the next done.
- owner  out  1  core currently holding the engine (0/1); valid while busy.
- busy  out  1  high in BUSY and DONE.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE behaviour:
  - Sample req0/req1.
  - One requester: that core wins.
  - Both requesting: the core indicated by priority pointer `prio` wins.
  - On accept: latch op and operands; set owner; pulse gntN; toggle `prio` to the other core; count := 0; go to BUSY.
- Signed ops (mult/div):
  - Operands are converted to magnitudes at accept, with signs saved.
  - Signs are applied in the final step.
  - Product sign = sa^sb; quotient sign = sa^sb; remainder sign = sa.
- BUSY, one iteration per cycle:
  - Multiply: radix-2 shift-add.
  - Divide: restoring shift-subtract.
  - count increments each cycle; at count == ITER-1, go to DONE.
- DONE: drive hi_out/lo_out; pulse done for the owner core; go to IDLE.
- Divide by zero (B == 0):
  - Accept goes straight to DONE.
  - Result: hi = A (unmodified), lo = 32'hFFFF_FFFF.
- div with 0x8000_0000 / -1: lo = 0x8000_0000, hi = 0. No trap is raised.
- A request still high in the cycle after done is treated as a new request. Cores must drop req on done.
- The losing core keeps its request pending; it is granted in the IDLE cycle following the DONE state.

## Timing
- Reset (reset == 0 at a rising edge):
  - State → IDLE; prio → core 0; owner → 0.
  - gnt*, done*, busy → 0; hi_out, lo_out → 0.
  - This aborts any in-flight operation with no done pulse.
- Latency for a normal operation, from the accepting edge E0:
  - gnt is high in cycle E0–E1.
  - BUSY lasts 32 cycles.
  - done is high in the cycle after edge E33.
  - The next accept can occur at edge E34.
- Divide-by-zero latency: done is high in the cycle after E1.
- stall follows req combinationally and drops in the done cycle.
- A request arriving in BUSY or DONE waits. It is not lost while held.

## Configuration
- MULDIV_FAST_MULT_EN
  - Defined: mult/multu compute the 64-bit product with a single-cycle multiplier and go IDLE → DONE, so done is high after E1. Divide is unchanged.
  - Undefined: all ops use the 32-iteration path.

## Structure
- Package muldiv_pkg holds:
  - muldiv_op_t enum (MULT, MULTU, DIV, DIVU);
  - muldiv_state_t enum (IDLE, BUSY, DONE);
  - the ITER default;
  - DIV0_LO constant 32'hFFFF_FFFF.
- Sub-module seq_muldiv_core holds the iterative datapath: accumulator, shift registers, counter and sign fix-up. It is driven by start/op/operands and returns a last-iteration flag plus the result.
- The arbiter holds the FSM, the priority pointer and the owner/handshake logic.

## Test plan
- multu: core 0 A=0xFFFF_FFFF, B=2 → gnt0 pulse; done0 33 cycles later; hi=0x1, lo=0xFFFF_FFFE.
- Signed div: core 1 A=-7, B=2 → lo=0xFFFF_FFFD (-3), hi=0xFFFF_FFFF (-1).
- Simultaneous requests: req0 and req1 in the same cycle after reset → core 0 served first, core 1 granted the cycle after done0; stall1 high throughout. Next simultaneous pair → core 0 is served first again, because prio returned to core 0 after core 1's grant.
- Divide by zero: divu A=0x1234, B=0 → done 1 cycle after accept; hi=0x1234, lo=0xFFFF_FFFF.
- Reset mid-operation: reset low at iteration 10 → next cycle busy=0, hi/lo=0, no done pulse; a new request proceeds normally.
- MULDIV_FAST_MULT_EN defined: mult A=-3, B=5 → done 1 cycle after accept; hi=0xFFFF_FFFF, lo=0xFFFF_FFF1.
